// File: rtl/hamming_err_sequencer_if.sv
// Result stream from the Hamming error-injection sequencer to its consumer.
// One beat per executed step, accepted when valid && ready.
interface hamming_err_sequencer_if #(
    parameter int POS_W = 8
);
    logic             valid;
    logic             ready;
    logic [4:0]       step;
    logic [POS_W-1:0] pos;
    logic             ok;

    modport master (output valid, output step, output pos, output ok, input ready);
    modport slave  (input valid, input step, input pos, input ok, output ready);
endinterface

// File: rtl/hamming_err_sequencer.sv
// Drives a combinational Hamming decoder through a baseline step plus one single-error
// step per enabled slot, checks the decoded data and streams per-step results.
module hamming_err_sequencer #(
    parameter int MSG_W     = 64,
    parameter int POS_W     = 8,
    parameter int NUM_SLOTS = 16,
    parameter int SETTLE    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [MSG_W-1:0]             cfg_msg,
    input  logic [NUM_SLOTS*POS_W-1:0]   cfg_err,
    output logic [MSG_W-1:0]             dut_message,
    output logic [NUM_SLOTS*POS_W-1:0]   dut_err,
    input  logic [MSG_W-1:0]             dut_decoded,
    input  logic [POS_W-1:0]             dut_err_pos,
    output logic                         busy,
    output logic                         done,
    hamming_err_sequencer_if.master      res,
    output logic [4:0]                   pass_cnt,
    output logic [4:0]                   fail_cnt
);
    localparam int ERR_W  = NUM_SLOTS * POS_W;
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [POS_W-1:0] SLOT_OFF = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [ERR_W-1:0] ALL_OFF  = {NUM_SLOTS{SLOT_OFF}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        APPLY   = 3'd2,
        CAPTURE = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [MSG_W-1:0]    msg_r;
    logic [ERR_W-1:0]    err_r;
    logic [4:0]          step_r;
    logic [SET_W-1:0]    settle_r;
    logic [NUM_SLOTS-1:0] slot_en_s;
    logic                found_s;
    logic [SLOT_W-1:0]   next_slot_s;

    // An out-of-range position cannot address a codeword bit, so it counts as disabled.
    function automatic logic slot_enabled(input logic [POS_W-1:0] slot);
        return (slot[POS_W-1] == 1'b0) && (int'(slot[POS_W-2:0]) < (MSG_W + 8));
    endfunction

    function automatic logic [ERR_W-1:0] one_slot(input logic [SLOT_W-1:0] idx,
                                                  input logic [ERR_W-1:0] err);
        logic [ERR_W-1:0] v;
        v = ALL_OFF;
        v[idx*POS_W +: POS_W] = err[idx*POS_W +: POS_W];
        return v;
    endfunction

    // Find the lowest enabled slot not yet executed (slot k belongs to step k+1).
    always_comb begin
        slot_en_s   = '0;
        found_s     = 1'b0;
        next_slot_s = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_en_s[k] = (k >= int'(step_r)) && slot_enabled(err_r[k*POS_W +: POS_W]);
        end
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            found_s     = found_s | slot_en_s[k];
            next_slot_s = slot_en_s[k] ? SLOT_W'(k) : next_slot_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = start ? LOAD : IDLE;
            LOAD:    state_next_s = APPLY;
            APPLY:   state_next_s = (settle_r == SET_W'(SETTLE - 1)) ? CAPTURE : APPLY;
            CAPTURE: state_next_s = EMIT;
            EMIT: begin
                if (res.ready) begin
                    state_next_s = found_s ? APPLY : DONE;
                end else begin
                    state_next_s = EMIT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: latched config, decoder drive, result capture and counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_r       <= '0;
            err_r       <= ALL_OFF;
            step_r      <= 5'd0;
            settle_r    <= '0;
            dut_message <= '0;
            dut_err     <= ALL_OFF;
            busy        <= 1'b0;
            done        <= 1'b0;
            res.valid   <= 1'b0;
            res.step    <= 5'd0;
            res.pos     <= '0;
            res.ok      <= 1'b0;
            pass_cnt    <= 5'd0;
            fail_cnt    <= 5'd0;
        end else begin
            busy <= (state_next_s != IDLE);
            done <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        msg_r    <= cfg_msg;
                        err_r    <= cfg_err;
                        step_r   <= 5'd0;
                        pass_cnt <= 5'd0;
                        fail_cnt <= 5'd0;
                    end
                end
                LOAD: begin
                    dut_message <= msg_r;
                    dut_err     <= ALL_OFF;
                    settle_r    <= '0;
                end
                APPLY: begin
                    settle_r <= settle_r + SET_W'(1);
                end
                CAPTURE: begin
                    res.valid <= 1'b1;
                    res.step  <= step_r;
                    res.pos   <= dut_err_pos;
                    res.ok    <= (dut_decoded == msg_r);
                    if (dut_decoded == msg_r) begin
                        pass_cnt <= pass_cnt + 5'd1;
                    end else begin
                        fail_cnt <= fail_cnt + 5'd1;
                    end
                end
                EMIT: begin
                    if (res.ready) begin
                        res.valid <= 1'b0;
                        settle_r  <= '0;
                        if (found_s) begin
                            step_r  <= 5'(next_slot_s) + 5'd1;
                            dut_err <= one_slot(next_slot_s, err_r);
                        end else begin
                            dut_err <= ALL_OFF;
                        end
                    end
                end
                DONE: begin
                    dut_err <= ALL_OFF;
                end
                default: begin
                    dut_err <= ALL_OFF;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_err_sequencer.sv
// Directed, table-driven bench for hamming_err_sequencer with a behavioural decoder stub.
module tb_hamming_err_sequencer;
    localparam int MSG_W = 64;
    localparam int POS_W = 8;
    localparam int NUM_SLOTS = 16;
    localparam int ERR_W = NUM_SLOTS * POS_W;
    localparam logic [ERR_W-1:0] ALL_OFF = {NUM_SLOTS{8'h80}};

    logic clk = 1'b0;
    logic rst, start;
    logic [MSG_W-1:0] cfg_msg, dut_message, dut_decoded;
    logic [ERR_W-1:0] cfg_err, dut_err;
    logic [POS_W-1:0] dut_err_pos;
    logic busy, done;
    logic [4:0] pass_cnt, fail_cnt;
    int corrupt_slot;

    hamming_err_sequencer_if #(.POS_W(POS_W)) res_if ();

    hamming_err_sequencer #(.MSG_W(MSG_W), .POS_W(POS_W), .NUM_SLOTS(NUM_SLOTS), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_msg(cfg_msg), .cfg_err(cfg_err),
        .dut_message(dut_message), .dut_err(dut_err), .dut_decoded(dut_decoded),
        .dut_err_pos(dut_err_pos), .busy(busy), .done(done), .res(res_if),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    // Stub decoder: reports the active slot position, corrects everything except corrupt_slot.
    always_comb begin
        dut_err_pos = 8'h7F;
        dut_decoded = dut_message;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (dut_err[k*8+7] == 1'b0) begin
                dut_err_pos = {1'b0, dut_err[k*8 +: 7]};
                if (k == corrupt_slot) dut_decoded = dut_message ^ 64'h1;
            end
        end
    end

    typedef struct {
        logic [4:0]       step;
        logic [7:0]       pos;
        logic             ok;
        logic [ERR_W-1:0] err;
    } beat_t;

    typedef struct {
        logic [MSG_W-1:0] msg;
        logic [ERR_W-1:0] err;
        int               corrupt;
        logic [16:0]      mask;
        logic [4:0]       pass;
        logic [4:0]       fail;
    } vec_t;

    beat_t beats[$];
    bit    mon_en = 1'b0;
    vec_t  vecs[4];
    int    n_cmp = 0;
    int    n_err = 0;

    always @(negedge clk) begin
        if (mon_en && res_if.valid && res_if.ready)
            beats.push_back('{res_if.step, res_if.pos, res_if.ok, dut_err});
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int g = 0; g < 300 && !seen; g++) begin
            @(posedge clk); #1;
            seen = done;
        end
        check({nm, "_done_seen"}, 128'(seen), 128'd1);
    endtask

    task automatic check_beats(input vec_t v, input string nm);
        int exp_steps[$];
        int s;
        logic [ERR_W-1:0] e;
        for (int i = 0; i <= 16; i++) if (v.mask[i]) exp_steps.push_back(i);
        check({nm, "_beat_count"}, 128'(beats.size()), 128'(exp_steps.size()));
        for (int i = 0; i < beats.size() && i < exp_steps.size(); i++) begin
            s = exp_steps[i];
            e = ALL_OFF;
            if (s > 0) e[(s-1)*8 +: 8] = v.err[(s-1)*8 +: 8];
            check({nm, "_step"}, 128'(beats[i].step), 128'(s));
            check({nm, "_pos"}, 128'(beats[i].pos),
                  (s == 0) ? 128'h7F : 128'({1'b0, v.err[(s-1)*8 +: 7]}));
            check({nm, "_ok"}, 128'(beats[i].ok), (s > 0 && s - 1 == v.corrupt) ? 128'd0 : 128'd1);
            check({nm, "_dut_err"}, 128'(beats[i].err), 128'(e));
        end
        check({nm, "_pass_cnt"}, 128'(pass_cnt), 128'(v.pass));
        check({nm, "_fail_cnt"}, 128'(fail_cnt), 128'(v.fail));
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        cfg_msg = v.msg; cfg_err = v.err; corrupt_slot = v.corrupt;
        res_if.ready = 1'b1;
        beats.delete();
        mon_en = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(nm);
        @(posedge clk); #1;
        check({nm, "_busy_after"}, 128'(busy), 128'd0);
        check({nm, "_done_pulse"}, 128'(done), 128'd0);
        check({nm, "_err_restored"}, 128'(dut_err), 128'(ALL_OFF));
        mon_en = 1'b0;
        check_beats(v, nm);
    endtask

    initial begin
        logic [ERR_W-1:0] e;
        int lat;
        bit got;

        vecs[0] = '{msg: 64'h0123456789ABCDEF, err: ALL_OFF, corrupt: -1,
                    mask: 17'h00001, pass: 5'd1, fail: 5'd0};
        vecs[1] = '{msg: 64'hDEADBEEFCAFEF00D, err: 128'h0F0E0D0C0B0A09080706050403020100,
                    corrupt: -1, mask: 17'h1FFFF, pass: 5'd17, fail: 5'd0};
        e = ALL_OFF; e[7:0] = 8'h01; e[15:8] = 8'h06; e[23:16] = 8'h09;
        vecs[2] = '{msg: 64'h5555AAAA3333CCCC, err: e, corrupt: 2,
                    mask: 17'h0000F, pass: 5'd3, fail: 5'd1};
        e = ALL_OFF; e[31:24] = 8'h50; e[47:40] = 8'h47; e[55:48] = 8'h48;
        e[63:56] = 8'hFF; e[127:120] = 8'h00;
        vecs[3] = '{msg: 64'hFFFF00001234FEDC, err: e, corrupt: -1,
                    mask: 17'h10041, pass: 5'd3, fail: 5'd0};

        rst = 1'b1; start = 1'b0; cfg_msg = '0; cfg_err = ALL_OFF;
        corrupt_slot = -1; res_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(res_if.valid), 128'd0);
        check("rst_dut_err", 128'(dut_err), 128'(ALL_OFF));
        check("rst_dut_msg", 128'(dut_message), 128'd0);
        check("rst_counts", 128'({pass_cnt, fail_cnt, res_if.step, res_if.pos, res_if.ok, done}), 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Latency, EMIT stall, start while busy and cfg change while busy.
        cfg_msg = vecs[2].msg; cfg_err = vecs[2].err; corrupt_slot = 2;
        res_if.ready = 1'b0; beats.delete(); mon_en = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("stall_busy_after_start", 128'(busy), 128'd1);
        cfg_msg = ~vecs[2].msg; cfg_err = {NUM_SLOTS{8'h03}};
        lat = 0; got = 1'b0;
        while (lat < 20 && !got) begin
            @(posedge clk); #1; lat++;
            got = res_if.valid;
        end
        check("first_beat_latency", 128'(lat), 128'd3);
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_hold", 128'({res_if.valid, res_if.step, res_if.pos, res_if.ok}),
                  128'({1'b1, 5'd0, 8'h7F, 1'b1}));
            check("stall_counts", 128'({pass_cnt, fail_cnt}), 128'({5'd1, 5'd0}));
            check("stall_dut_err", 128'(dut_err), 128'(ALL_OFF));
        end
        start = 1'b0; res_if.ready = 1'b1;
        wait_done("stall");
        repeat (2) @(posedge clk);
        #1;
        check("no_restart", 128'(busy), 128'd0);
        mon_en = 1'b0;
        check_beats(vecs[2], "stall");

        // Reset in the middle of EMIT drops the pending beat.
        cfg_msg = vecs[1].msg; cfg_err = vecs[1].err; corrupt_slot = -1;
        res_if.ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int g = 0; g < 20 && !got; g++) begin
            @(posedge clk); #1;
            got = res_if.valid;
        end
        check("midrun_valid_seen", 128'(got), 128'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrun_rst_valid", 128'(res_if.valid), 128'd0);
        check("midrun_rst_busy", 128'(busy), 128'd0);
        check("midrun_rst_dut_err", 128'(dut_err), 128'(ALL_OFF));
        check("midrun_rst_counts", 128'({pass_cnt, fail_cnt}), 128'd0);
        rst = 1'b0; res_if.ready = 1'b1;
        @(posedge clk); #1;
        check("midrun_idle", 128'({busy, res_if.valid}), 128'd0);
        run_vec(vecs[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
